// File: rtl/pcv32_mem_pkg.sv
// pcv32_mem_pkg: shared state encoding, LFSR taps, error bit positions and range helper
package pcv32_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int ERR_DROP  = 0;
    localparam int ERR_CHG   = 1;
    localparam int ERR_RANGE = 2;

    function automatic logic in_range(input logic [31:0] addr, input int words);
        return {2'b00, addr[31:2]} < 32'(words);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), steps every cycle out of reset
module lfsr16
    import pcv32_mem_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            value <= seed;
        else
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    end

endmodule

// File: rtl/pcv32_mem_responder.sv
// pcv32_mem_responder: PicoRV32-style memory slave with random wait states,
// protocol error flags and an instruction-fetch counter
module pcv32_mem_responder
    import pcv32_mem_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter int          MAX_WAIT  = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall_en,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [2:0]  err,
    output logic [31:0] fetch_cnt
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    state_t      state, state_nx;
    logic [31:0] addr_q, wdata_q, rdata_q, fetch_q;
    logic [3:0]  wstrb_q, cur_wstrb;
    logic        instr_q;
    logic [2:0]  cnt_q, n_wait, err_q;
    logic [15:0] lfsr_val;
    logic [31:0] cur_addr;
    logic        cur_ok, ack, start, to_ack, drop, chg;
    logic        unused_lfsr;
    logic [31:0] ram [MEM_WORDS];

    lfsr16 u_lfsr (
        .clk   (clk),
        .resetn(resetn),
        .seed  (LFSR_SEED),
        .value (lfsr_val)
    );

    assign unused_lfsr = ^lfsr_val[15:3];

    // In IDLE the live request is used; afterwards only the latched copy counts
    assign cur_addr  = (state == S_IDLE) ? mem_addr : addr_q;
    assign cur_wstrb = (state == S_IDLE) ? mem_wstrb : wstrb_q;
    assign cur_ok    = in_range(cur_addr, MEM_WORDS);
    assign ack       = (state == S_ACK);
    assign start     = (state == S_IDLE) && mem_valid;
    assign drop      = (state == S_WAIT) && !mem_valid;
    assign chg       = (state != S_IDLE) &&
                       ((mem_addr != addr_q) || (mem_wdata != wdata_q) || (mem_wstrb != wstrb_q));

    always_comb begin
        n_wait   = !stall_en ? 3'd0 :
                   (lfsr_val[2:0] > 3'(MAX_WAIT)) ? 3'(MAX_WAIT) : lfsr_val[2:0];
        to_ack   = (start && n_wait == 3'd0) ||
                   ((state == S_WAIT) && mem_valid && cnt_q == 3'd1);
        state_nx = (state == S_IDLE) ? (mem_valid ? ((n_wait == 3'd0) ? S_ACK : S_WAIT) : S_IDLE) :
                   (state == S_WAIT) ? (!mem_valid ? S_IDLE : (cnt_q == 3'd1) ? S_ACK : S_WAIT) :
                   S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            instr_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= '0;
            fetch_q <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
                instr_q <= mem_instr;
                cnt_q   <= n_wait;
            end else if (state == S_WAIT) begin
                cnt_q <= cnt_q - 3'd1;
            end
            rdata_q <= (to_ack && cur_wstrb == 4'h0 && cur_ok) ? ram[cur_addr[AW+1:2]] : 32'h0;
            if (drop)
                err_q[ERR_DROP] <= 1'b1;
            if (chg)
                err_q[ERR_CHG] <= 1'b1;
            if (start && !cur_ok)
                err_q[ERR_RANGE] <= 1'b1;
            if (ack && instr_q)
                fetch_q <= fetch_q + 32'd1;
        end
    end

    // RAM has no reset; an async reset forces IDLE, so a pending write is dropped
    always_ff @(posedge clk) begin
        if (ack && wstrb_q != 4'h0 && in_range(addr_q, MEM_WORDS))
            for (int i = 0; i < 4; i++)
                if (wstrb_q[i])
                    ram[addr_q[AW+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
    end

    assign mem_ready = ack;
    assign mem_rdata = rdata_q;
    assign err       = err_q;
    assign fetch_cnt = fetch_q;

endmodule

// File: tb/tb_pcv32_mem_responder.sv
// tb_pcv32_mem_responder: directed checks of handshake latency, byte lanes,
// wait-state spread, error flags, fetch counting and reset behaviour
module tb_pcv32_mem_responder;

    logic        clk = 1'b0;
    logic        resetn, stall_en, mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [2:0]  err;
    logic [31:0] fetch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pcv32_mem_responder dut (
        .clk      (clk),
        .resetn   (resetn),
        .stall_en (stall_en),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .err      (err),
        .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic ins, output logic [31:0] rd, output int lat);
        @(negedge clk);
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_instr = ins;
        mem_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_ready && lat < 16);
        if (!mem_ready)
            check("xfer_timeout", 32'(mem_ready), 32'h1);
        rd = mem_rdata;
        mem_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, exp_mem;
        int          lat, bad, rbad;
        bit          seen [1:5];
        bit          got_wait, rdy;

        resetn = 1'b0; stall_en = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(mem_ready), 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_fetch", fetch_cnt, 32'h0);
        resetn = 1'b1;

        // zero-wait write then read
        xfer(32'h100, 32'hDEADBEEF, 4'hF, 1'b0, rd, lat);
        check("wr_lat", 32'(lat), 32'd1);
        check("wr_rdata_zero", rd, 32'h0);
        xfer(32'h100, 32'h0, 4'h0, 1'b0, rd, lat);
        check("rd_lat", 32'(lat), 32'd1);
        check("rd_data", rd, 32'hDEADBEEF);

        // byte lanes: word 0x40 (byte 0x100)
        xfer(32'h100, 32'h11223344, 4'hF, 1'b0, rd, lat);
        xfer(32'h100, 32'hAABBCCDD, 4'b0101, 1'b0, rd, lat);
        xfer(32'h100, 32'h0, 4'h0, 1'b0, rd, lat);
        check("lane_merge", rd, 32'h11BB33DD);
        xfer(32'h0, 32'h12345678, 4'hF, 1'b0, rd, lat);

        // five fetches, two data reads
        for (int i = 0; i < 5; i++)
            xfer(32'h100, 32'h0, 4'h0, 1'b1, rd, lat);
        check("fetch_rdata", rd, 32'h11BB33DD);
        xfer(32'h0, 32'h0, 4'h0, 1'b0, rd, lat);
        check("rd_word0", rd, 32'h12345678);
        xfer(32'h100, 32'h0, 4'h0, 1'b0, rd, lat);
        check("fetch_cnt", fetch_cnt, 32'd5);
        check("err_clean", 32'(err), 32'h0);

        // random wait states
        stall_en = 1'b1;
        bad = 0; rbad = 0;
        for (int l = 1; l <= 5; l++) seen[l] = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            xfer(32'h100, 32'h0, 4'h0, 1'b0, rd, lat);
            if (lat < 1 || lat > 5) bad++;
            else seen[lat] = 1'b1;
            if (rd !== 32'h11BB33DD) rbad++;
        end
        check("lat_range", 32'(bad), 32'd0);
        for (int l = 1; l <= 5; l++)
            check($sformatf("lat_seen_%0d", l), 32'(seen[l]), 32'h1);
        check("stall_rdata", 32'(rbad), 32'd0);
        check("stall_err", 32'(err), 32'h0);
        check("stall_fetch", fetch_cnt, 32'd5);

        // out of range: read returns 0, write must not alias onto word 0
        stall_en = 1'b0;
        xfer(32'h1000, 32'h0, 4'h0, 1'b0, rd, lat);
        check("oor_lat", 32'(lat), 32'd1);
        check("oor_rdata", rd, 32'h0);
        check("oor_err", 32'(err), 32'h4);
        xfer(32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, rd, lat);
        xfer(32'h0, 32'h0, 4'h0, 1'b0, rd, lat);
        check("oor_no_alias", rd, 32'h12345678);

        // address changes during ACK: latched address wins, err[1] set
        @(negedge clk);
        mem_addr = 32'h100; mem_wstrb = 4'h0; mem_wdata = 32'h0; mem_valid = 1'b1;
        @(negedge clk);
        check("chg_ready", 32'(mem_ready), 32'h1);
        check("chg_rdata", mem_rdata, 32'h11BB33DD);
        mem_addr = 32'h104; mem_valid = 1'b0;
        @(negedge clk);
        check("chg_err", 32'(err), 32'h6);

        // drop mem_valid in WAIT
        stall_en = 1'b1; got_wait = 1'b0;
        for (int t = 0; t < 40 && !got_wait; t++) begin
            @(negedge clk);
            mem_addr = 32'h100; mem_wstrb = 4'h0; mem_valid = 1'b1;
            @(negedge clk);
            got_wait = !mem_ready;
            mem_valid = 1'b0;
        end
        check("drop_got_wait", 32'(got_wait), 32'h1);
        rdy = 1'b0;
        repeat (8) begin
            @(negedge clk);
            rdy |= mem_ready;
        end
        check("drop_no_ready", 32'(rdy), 32'h0);
        check("drop_err", 32'(err), 32'h7);

        // reset in WAIT during a write: RAM keeps its old word
        exp_mem = 32'h11BB33DD; got_wait = 1'b0;
        for (int t = 0; t < 40 && !got_wait; t++) begin
            @(negedge clk);
            mem_addr = 32'h100; mem_wdata = 32'hCAFEF00D; mem_wstrb = 4'hF; mem_valid = 1'b1;
            @(negedge clk);
            if (mem_ready) begin
                exp_mem = 32'hCAFEF00D;
                mem_valid = 1'b0;
            end else begin
                got_wait = 1'b1;
                resetn = 1'b0;
            end
        end
        check("rst_got_wait", 32'(got_wait), 32'h1);
        #1;
        check("rstw_ready", 32'(mem_ready), 32'h0);
        check("rstw_rdata", mem_rdata, 32'h0);
        check("rstw_err", 32'(err), 32'h0);
        check("rstw_fetch", fetch_cnt, 32'h0);
        mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        stall_en = 1'b0;
        xfer(32'h100, 32'h0, 4'h0, 1'b0, rd, lat);
        check("rstw_ram_kept", rd, exp_mem);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pcv32_mem_responder.md
PCV32_MEM_RESPONDER -- requirements
Module: pcv32_mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024, number of 32-bit words in the backing RAM.
REQ-002 Parameter MAX_WAIT, default 4, maximum inserted wait cycles per transfer (range 0..7).
REQ-003 Parameter LFSR_SEED, default 16'hACE1, reset value of the wait-state LFSR (nonzero).
REQ-004 clk  input  1  single clock, all state rising-edge.
REQ-005 resetn  input  1  reset, asynchronous assert, active-low.
REQ-006 stall_en  input  1  1 = random wait states, 0 = zero-wait operation.
REQ-007 mem_valid  input  1  core request strobe.
REQ-008 mem_instr  input  1  request is an instruction fetch.
REQ-009 mem_addr  input  32  byte address; word index = mem_addr[31:2].
REQ-010 mem_wdata  input  32  write data.
REQ-011 mem_wstrb  input  4  byte write enables; 0 = read.
REQ-012 mem_ready  output  1  one-cycle transfer-complete strobe.
REQ-013 mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-014 err  output  3  sticky errors: [0] valid dropped early, [1] request changed mid-transfer, [2] address out of range.
REQ-015 fetch_cnt  output  32  count of completed mem_instr=1 transfers, wraps at 2^32.

Function
REQ-016 FSM states IDLE, WAIT, ACK; IDLE at reset.
REQ-017 IDLE with mem_valid=1: latch addr/wdata/wstrb/instr, load wait count N = min(lfsr[2:0], MAX_WAIT) if stall_en else 0; go ACK if N=0, else WAIT.
REQ-018 WAIT: decrement count each cycle; at count=1 go ACK.
REQ-019 ACK: mem_ready=1 for exactly one cycle, then IDLE; latency mem_valid-seen to mem_ready = 1+N cycles.
REQ-020 Read (wstrb=0): mem_rdata = RAM[word] during ACK; mem_rdata=0 in all other cycles.
REQ-021 Write: on the ACK-cycle edge write only lanes with wstrb[i]=1; mem_rdata=0 during a write ACK.
REQ-022 Word index >= MEM_WORDS: set err[2], read returns 0, write ignored, handshake otherwise normal.
REQ-023 mem_valid=0 in WAIT: set err[0], abort to IDLE, no ACK, no write.
REQ-024 mem_addr/mem_wdata/mem_wstrb differ from latched value in WAIT or ACK: set err[1]; latched values are used.
REQ-025 mem_valid sampled in the cycle after ACK starts a new transfer (back-to-back allowed).
REQ-026 LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle out of reset.
REQ-027 fetch_cnt increments on ACK with latched instr=1.
REQ-028 err bits clear only on reset.

Reset
REQ-029 resetn=0 asynchronously forces state IDLE, mem_ready=0, mem_rdata=0, err=0, fetch_cnt=0, lfsr=LFSR_SEED.
REQ-030 Reset mid-transfer aborts without writing; RAM contents are not reset.

Structure
REQ-031 Package pcv32_mem_pkg holds the state enum, LFSR tap constant 16'hB400, and err bit index constants.
REQ-032 LFSR is a sub-module lfsr16 (clk, resetn, seed, value).

Verification
REQ-033 stall_en=0, write 0xDEADBEEF wstrb=4'hF to 0x100, then read 0x100 -> each mem_ready 1 cycle after valid, rdata=0xDEADBEEF.
REQ-034 RAM[0x40]=0x11223344, write 0xAABBCCDD wstrb=4'b0101, read -> 0x11BB33DD.
REQ-035 stall_en=1, 1000 reads -> all latencies in 1..MAX_WAIT+1, every value 1..5 seen, err=0.
REQ-036 Read 0x00001000 with MEM_WORDS=1024 -> mem_ready after 1+N cycles, rdata=0, err=3'b100.
REQ-037 stall_en=1, drop mem_valid in WAIT -> no mem_ready, err[0]=1; reset mid-WAIT on a write -> RAM unchanged, outputs 0.
REQ-038 Five fetches with mem_instr=1, two data reads -> fetch_cnt=5.
